e_mdu: RTL and testbench



---
 rtl/e_mdu_pkg.sv | 39 +++
 rtl/e_mdu_calc.sv | 64 ++++++
 rtl/e_mdu.sv | 114 +++++++++++
 tb/tb_e_mdu.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/e_mdu_pkg.sv
// Shared MDU definitions: op codes, op width and default latencies.
// MDU_MADD_EN enables the accumulate ops (codes 9-12).
package e_mdu_pkg;

    localparam int unsigned MDU_OP_W = 4;

    localparam logic [MDU_OP_W-1:0] MDU_NONE  = 4'd0;
    localparam logic [MDU_OP_W-1:0] MDU_MULT  = 4'd1;
    localparam logic [MDU_OP_W-1:0] MDU_MULTU = 4'd2;
    localparam logic [MDU_OP_W-1:0] MDU_DIV   = 4'd3;
    localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 4'd4;
    localparam logic [MDU_OP_W-1:0] MDU_MFHI  = 4'd5;
    localparam logic [MDU_OP_W-1:0] MDU_MFLO  = 4'd6;
    localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 4'd7;
    localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 4'd8;
    localparam logic [MDU_OP_W-1:0] MDU_MADD  = 4'd9;
    localparam logic [MDU_OP_W-1:0] MDU_MADDU = 4'd10;
    localparam logic [MDU_OP_W-1:0] MDU_MSUB  = 4'd11;
    localparam logic [MDU_OP_W-1:0] MDU_MSUBU = 4'd12;

    localparam int unsigned MDU_MULT_CYCLES = 5;
    localparam int unsigned MDU_DIV_CYCLES  = 10;

    typedef enum logic [1:0] {ClsNone, ClsMul, ClsDiv} mdu_cls_e;
    typedef enum logic {StIdle, StRun} mdu_state_e;

    // Which ops start a multi-cycle run, and which latency they use.
    function automatic mdu_cls_e mdu_op_class(input logic [MDU_OP_W-1:0] op);
        case (op)
            MDU_MULT, MDU_MULTU: return ClsMul;
            MDU_DIV, MDU_DIVU:   return ClsDiv;
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: return ClsMul;
`endif
            default: return ClsNone;
        endcase
    endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational MDU datapath: 64-bit products, quotient/remainder and, with
// MDU_MADD_EN, the HI/LO accumulate. Divide-by-zero passes the old HI/LO through.
module e_mdu_calc
    import e_mdu_pkg::*;
(
    input  logic [MDU_OP_W-1:0] op,
    input  logic [31:0]         a,
    input  logic [31:0]         b,
    input  logic [31:0]         hi,
    input  logic [31:0]         lo,
    output logic [31:0]         res_hi,
    output logic [31:0]         res_lo
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        signed_div;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    // Sign-extended 64x64 multiply truncated to 64 bits equals the signed product.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // One unsigned divider on magnitudes; signs restored afterwards. This also
    // makes 0x80000000 / -1 wrap to 0x80000000 without any special case.
    always_comb begin
        signed_div = (op == MDU_DIV);
        a_mag      = (signed_div && a[31]) ? 32'd0 - a : a;
        b_mag      = (signed_div && b[31]) ? 32'd0 - b : b;
        b_safe     = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag      = a_mag / b_safe;
        r_mag      = a_mag % b_safe;
        quo        = (signed_div && (a[31] ^ b[31])) ? 32'd0 - q_mag : q_mag;
        rem        = (signed_div && a[31]) ? 32'd0 - r_mag : r_mag;
    end

    always_comb begin
        {res_hi, res_lo} = {hi, lo};
        case (op)
            MDU_MULT:  {res_hi, res_lo} = prod_s;
            MDU_MULTU: {res_hi, res_lo} = prod_u;
            MDU_DIV, MDU_DIVU: begin
                if (b != 32'd0) begin
                    res_hi = rem;
                    res_lo = quo;
                end
            end
`ifdef MDU_MADD_EN
            MDU_MADD:  {res_hi, res_lo} = {hi, lo} + prod_s;
            MDU_MADDU: {res_hi, res_lo} = {hi, lo} + prod_u;
            MDU_MSUB:  {res_hi, res_lo} = {hi, lo} - prod_s;
            MDU_MSUBU: {res_hi, res_lo} = {hi, lo} - prod_u;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: HI/LO, busy counter and shadow results.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [MDU_OP_W-1:0] mdu_op,
    input  logic [31:0]         A,
    input  logic [31:0]         B,
    output logic                busy,
    output logic [31:0]         hi,
    output logic [31:0]         lo,
    output logic [31:0]         out
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    mdu_state_e  state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic [31:0] calc_hi;
    logic [31:0] calc_lo;
    mdu_cls_e    cls;

    e_mdu_calc u_calc (
        .op     (mdu_op),
        .a      (A),
        .b      (B),
        .hi     (hi_q),
        .lo     (lo_q),
        .res_hi (calc_hi),
        .res_lo (calc_lo)
    );

    always_comb begin
        cls      = mdu_op_class(mdu_op);
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (cls != ClsNone) begin
                        res_hi_d = calc_hi;
                        res_lo_d = calc_lo;
                        state_d  = StRun;
                        cnt_d    = (cls == ClsDiv) ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
                    end else if (mdu_op == MDU_MTHI) begin
                        hi_d = A;
                    end else if (mdu_op == MDU_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            StRun: begin
                // Starts arriving here are dropped; the hazard unit should prevent them.
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                    hi_d    = res_hi_q;
                    lo_d    = res_lo_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
        end
    end

    always_comb begin
        out = '0;
        case (mdu_op)
            MDU_MFHI: out = hi_q;
            MDU_MFLO: out = lo_q;
            default:  ;
        endcase
    end

    assign busy = (state_q == StRun);
    assign hi   = hi_q;
    assign lo   = lo_q;

    start_while_busy_a: assert property (@(posedge clk) disable iff (rst) !(start && busy))
        else $warning("e_mdu: start while busy ignored");

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed cases plus randomized ops against a
// wide-integer reference model. Honours MDU_MADD_EN like the RTL.
module tb_e_mdu;
    import e_mdu_pkg::*;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  mdu_op = MDU_NONE;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] out;

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mdu_op (mdu_op),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .out    (out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference model: architectural HI/LO plus one pending result with its
    // remaining busy time.
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] m_phi = '0;
    logic [31:0] m_plo = '0;
    bit          m_pwr = 1'b0;
    int          m_left = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [63:0] p_s;
        logic [63:0] p_u;
        longint      sa;
        longint      sb;
        if (rst) begin
            m_hi = '0; m_lo = '0; m_left = 0; m_pwr = 1'b0;
            return;
        end
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_pwr) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
            return;
        end
        if (!start) return;
        sa    = longint'($signed(A));
        sb    = longint'($signed(B));
        p_s   = 64'(sa * sb);
        p_u   = {32'd0, A} * {32'd0, B};
        m_pwr = 1'b1;
        case (mdu_op)
            MDU_MULT:  begin {m_phi, m_plo} = p_s; m_left = MC; end
            MDU_MULTU: begin {m_phi, m_plo} = p_u; m_left = MC; end
            MDU_DIV: begin
                m_left = DC;
                if (B == 0) m_pwr = 1'b0;
                else begin m_plo = 32'(sa / sb); m_phi = 32'(sa % sb); end
            end
            MDU_DIVU: begin
                m_left = DC;
                if (B == 0) m_pwr = 1'b0;
                else begin m_plo = A / B; m_phi = A % B; end
            end
            MDU_MTHI: m_hi = A;
            MDU_MTLO: m_lo = A;
`ifdef MDU_MADD_EN
            MDU_MADD:  begin {m_phi, m_plo} = {m_hi, m_lo} + p_s; m_left = MC; end
            MDU_MADDU: begin {m_phi, m_plo} = {m_hi, m_lo} + p_u; m_left = MC; end
            MDU_MSUB:  begin {m_phi, m_plo} = {m_hi, m_lo} - p_s; m_left = MC; end
            MDU_MSUBU: begin {m_phi, m_plo} = {m_hi, m_lo} - p_u; m_left = MC; end
`endif
            default: ;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; mdu_op = op; A = a; B = b;
        step();
        start = 1'b0; mdu_op = MDU_NONE;
    endtask

    task automatic wait_done();
        int n = 0;
        while (m_left > 0 && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic expect_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
        @(negedge clk);
        check({name, ".hi"}, hi, eh);
        check({name, ".lo"}, lo, el);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'd0, busy}, {31'd0, m_left > 0});
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
            check("out", out, (mdu_op == MDU_MFHI) ? m_hi : (mdu_op == MDU_MFLO) ? m_lo : 32'd0);
        end
    end

    initial begin
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset.busy", {31'd0, busy}, 32'd0);
        check("reset.hi", hi, 32'd0);
        check("reset.lo", lo, 32'd0);

        // MULT -2 * 3: busy exactly MC cycles, MFHI shows old hi meanwhile.
        issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3);
        mdu_op = MDU_MFHI;
        for (int i = 0; i < int'(MC); i++) begin
            @(negedge clk);
            check("mult.busy_hi", {31'd0, busy}, 32'd1);
            check("mult.mfhi_old", out, 32'd0);
            step();
        end
        @(negedge clk);
        check("mult.busy_lo", {31'd0, busy}, 32'd0);
        check("mult.hi", hi, 32'hFFFF_FFFF);
        check("mult.lo", lo, 32'hFFFF_FFFA);
        mdu_op = MDU_NONE;

        issue(MDU_DIVU, 32'd100, 32'd7);
        wait_done();
        expect_hilo("divu", 32'd2, 32'd14);

        issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done();
        expect_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        issue(MDU_MTHI, 32'h1234_5678, 32'd0);
        @(negedge clk);
        check("mthi.busy", {31'd0, busy}, 32'd0);
        issue(MDU_MTLO, 32'h9ABC_DEF0, 32'd0);
        @(negedge clk);
        check("mtlo.busy", {31'd0, busy}, 32'd0);
        expect_hilo("mthilo", 32'h1234_5678, 32'h9ABC_DEF0);

        issue(MDU_DIV, 32'd55, 32'd0);
        wait_done();
        expect_hilo("div0", 32'h1234_5678, 32'h9ABC_DEF0);

        issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done();
        expect_hilo("div_ovf", 32'd0, 32'h8000_0000);

        // Start during busy is dropped.
        issue(MDU_DIVU, 32'd1000, 32'd3);
        step();
        issue(MDU_MULT, 32'd2, 32'd2);
        wait_done();
        expect_hilo("busy_start", 32'd1, 32'd333);

        // Reset in the third busy cycle aborts with no late update.
        issue(MDU_MULT, 32'd5, 32'd5);
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_abort.busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 6; i++) step();
        expect_hilo("rst_abort", 32'd0, 32'd0);

`ifdef MDU_MADD_EN
        issue(MDU_MTLO, 32'd5, 32'd0);
        issue(MDU_MTHI, 32'd0, 32'd0);
        issue(MDU_MADD, 32'd3, 32'd4);
        wait_done();
        expect_hilo("madd", 32'd0, 32'd17);
        issue(MDU_MSUBU, 32'd1, 32'd18);
        wait_done();
        expect_hilo("msubu", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`else
        issue(MDU_MTLO, 32'd5, 32'd0);
        issue(MDU_MADD, 32'd3, 32'd4);
        @(negedge clk);
        check("op9.busy", {31'd0, busy}, 32'd0);
        expect_hilo("op9", 32'd0, 32'd5);
`endif

        // Randomized phase; starts only when idle, as the hazard unit guarantees.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = $urandom_range(1, 9);
                3: ra = 32'(-int'($urandom_range(0, 50)));
                default: ;
            endcase
            rst   = ($urandom_range(0, 299) == 0);
            start = (m_left == 0) && ($urandom_range(0, 2) == 0);
            mdu_op = 4'($urandom_range(0, 12));
            A = ra;
            B = rb;
            step();
        end
        start = 1'b0;
        rst   = 1'b0;
        mdu_op = MDU_NONE;
        wait_done();
        step();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
